// File: rtl/conv_pkg.sv
// Shared constants and types for the CONV accelerator host-side memory responder.
package conv_pkg;
    localparam int DW        = 20;
    localparam int AW        = 12;
    localparam int IMG_DEPTH = 4096;
    localparam int L1_DEPTH  = 1024;
    localparam int L1_AW     = 10;

    localparam logic [2:0] CSEL_L0 = 3'b001;
    localparam logic [2:0] CSEL_L1 = 3'b011;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } host_state_t;

    // Which bank produced the pending layer-read data.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_L0,
        SRC_L1
    } csrc_t;
endpackage

// File: rtl/conv_spram.sv
// Single write port, registered read port RAM; contents are never reset.
module conv_spram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 20,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Read samples the array before the same-edge write lands: read-before-write.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/conv_mem_host.sv
// Host memory responder: loads the image, hands off to the accelerator, serves its
// bank accesses, then streams layer-1 results out on a valid/ready port.
module conv_mem_host
    import conv_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          ready,
    input  logic          busy,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic          cwr,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic [2:0]    csel,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    input  logic          rd_ready,
    output logic          done,
    output host_state_t   dbg_state_o
);
    host_state_t      state_q;
    logic [AW-1:0]    ld_cnt_q;
    logic             ld_ready_q, ready_q, done_q;
    logic             rd_valid_q, rd_last_q;
    logic [DW-1:0]    rd_data_q;
    logic [L1_AW-1:0] rd_addr_q;
    logic             issue_q, cap_q;
    logic             img_src_q, cpend_q;
    csrc_t            csrc_q;
    logic [DW-1:0]    chold_q, cdata_mux;
    logic [DW-1:0]    img_rdata, l0_rdata, l1_rdata;
    logic             run, sel_l0, sel_l1, hs;
    logic             img_we, l0_we, l0_re, l1_we, l1_re;
    logic [L1_AW-1:0] l1_raddr;

    assign run    = (state_q == ST_RUN);
    assign sel_l0 = (csel == CSEL_L0);
    assign sel_l1 = (csel == CSEL_L1);
    // Readout: a word moves on any edge where rd_valid && rd_ready; while
    // rd_valid && !rd_ready, rd_data/rd_last hold and rd_valid stays high.
    assign hs     = rd_valid_q && rd_ready;

    assign img_we = (state_q == ST_LOAD) && ld_valid;
    assign l0_we  = run && cwr && sel_l0;
    assign l0_re  = run && crd && sel_l0;
    assign l1_we  = run && cwr && sel_l1;
    // In DRAIN the L1 read port belongs to the readout; host reads return 0 there.
    assign l1_re    = (run && crd && sel_l1) || issue_q || (hs && !rd_last_q);
    assign l1_raddr = (state_q == ST_DRAIN)
                    ? (issue_q ? rd_addr_q : rd_addr_q + L1_AW'(1))
                    : caddr_rd[L1_AW-1:0];

    conv_spram #(.DEPTH(IMG_DEPTH), .WIDTH(DW)) u_img (
        .clk_i(clk), .we_i(img_we), .waddr_i(ld_cnt_q), .wdata_i(ld_data),
        .re_i(run), .raddr_i(iaddr), .rdata_o(img_rdata)
    );

    conv_spram #(.DEPTH(IMG_DEPTH), .WIDTH(DW)) u_l0 (
        .clk_i(clk), .we_i(l0_we), .waddr_i(caddr_wr), .wdata_i(cdata_wr),
        .re_i(l0_re), .raddr_i(caddr_rd), .rdata_o(l0_rdata)
    );

    conv_spram #(.DEPTH(L1_DEPTH), .WIDTH(DW)) u_l1 (
        .clk_i(clk), .we_i(l1_we), .waddr_i(caddr_wr[L1_AW-1:0]), .wdata_i(cdata_wr),
        .re_i(l1_re), .raddr_i(l1_raddr), .rdata_o(l1_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_LOAD;
            ld_cnt_q   <= '0;
            ld_ready_q <= 1'b1;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_last_q  <= 1'b0;
            rd_addr_q  <= '0;
            issue_q    <= 1'b0;
            cap_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_LOAD: begin
                    if (ld_valid) begin
                        ld_cnt_q <= ld_cnt_q + AW'(1);
                        if (ld_cnt_q == AW'(IMG_DEPTH - 1)) begin
                            state_q    <= ST_START;
                            ld_ready_q <= 1'b0;
                            ready_q    <= 1'b1;
                        end
                    end
                end
                ST_START: begin
                    if (busy) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!busy) begin
                        state_q   <= ST_DRAIN;
                        rd_addr_q <= '0;
                        issue_q   <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // issue -> RAM read -> capture; the next fetch is issued on the handshake
                    issue_q <= 1'b0;
                    cap_q   <= issue_q || (hs && !rd_last_q);
                    if (cap_q) begin
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= l1_rdata;
                        rd_last_q  <= (rd_addr_q == L1_AW'(L1_DEPTH - 1));
                    end else if (hs) begin
                        rd_valid_q <= 1'b0;
                        if (rd_last_q) begin
                            state_q   <= ST_DONE;
                            done_q    <= 1'b1;
                            rd_last_q <= 1'b0;
                        end else begin
                            rd_addr_q <= rd_addr_q + L1_AW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_q    <= ST_LOAD;
                    ld_cnt_q   <= '0;
                    ld_ready_q <= 1'b1;
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    // The RAM output registers are unreset, so these flags gate them to 0 / hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            img_src_q <= 1'b0;
            cpend_q   <= 1'b0;
            csrc_q    <= SRC_NONE;
            chold_q   <= '0;
        end else begin
            img_src_q <= run;
            cpend_q   <= crd;
            chold_q   <= cdata_rd;
            if (crd) begin
                if (run && sel_l0)      csrc_q <= SRC_L0;
                else if (run && sel_l1) csrc_q <= SRC_L1;
                else                    csrc_q <= SRC_NONE;
            end
        end
    end

    always_comb begin
        cdata_mux = '0;
        case (csrc_q)
            SRC_L0:  cdata_mux = l0_rdata;
            SRC_L1:  cdata_mux = l1_rdata;
            default: cdata_mux = '0;
        endcase
    end

    assign cdata_rd    = cpend_q ? cdata_mux : chold_q;
    assign idata       = img_src_q ? img_rdata : '0;
    assign ld_ready    = ld_ready_q;
    assign ready       = ready_q;
    assign done        = done_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign rd_last     = rd_last_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_conv_mem_host.sv
// Self-checking bench for conv_mem_host against array-based bank models.
module tb_conv_mem_host;
    import conv_pkg::*;

    logic          clk = 1'b0;
    logic          reset, ld_valid, busy, crd, cwr, rd_ready;
    logic [DW-1:0] ld_data, cdata_wr;
    logic [AW-1:0] iaddr, caddr_rd, caddr_wr;
    logic [2:0]    csel;
    logic          ld_ready, ready, rd_valid, rd_last, done;
    logic [DW-1:0] idata, cdata_rd, rd_data;
    host_state_t   dbg_state;

    logic [DW-1:0] img_m [IMG_DEPTH];
    logic [DW-1:0] l0_m  [IMG_DEPTH];
    logic [DW-1:0] l1_m  [L1_DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] cdata_exp;
    logic [2:0]    sels [5] = '{3'b001, 3'b011, 3'b010, 3'b000, 3'b111};
    int            n_cmp = 0;
    int            n_err = 0;

    conv_mem_host dut (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata), .crd(crd),
        .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .cwr(cwr), .caddr_wr(caddr_wr),
        .cdata_wr(cdata_wr), .csel(csel), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_last(rd_last), .rd_ready(rd_ready), .done(done), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] pick_addr(input logic [2:0] sel);
        logic [3:0] lo;
        lo = 4'($urandom_range(0, 15));
        if (sel == CSEL_L1) return {2'($urandom_range(0, 3)), 6'b0, lo};
        return {8'b0, lo};
    endfunction

    task automatic load_image(input bit random_data);
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < IMG_DEPTH && guard < 20000) begin
            guard++;
            check("load_ld_ready", ld_ready, 1);
            check("load_ready", ready, 0);
            check("load_idata", idata, 0);
            iaddr = AW'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                ld_valid = 1'b0;
            end else begin
                ld_valid = 1'b1;
                ld_data  = random_data ? DW'($urandom) : DW'(i);
                img_m[i] = ld_data;
                i++;
            end
            @(negedge clk);
        end
        ld_valid = 1'b0;
        check("load_count", i, IMG_DEPTH);
        check("load_end_ready", ready, 1);
        check("load_end_ld_ready", ld_ready, 0);
        check("load_end_state", 32'(dbg_state), 32'(ST_START));
    endtask

    task automatic start_seq(input int wait_cycles, input bit noise);
        busy = 1'b0;
        if (noise) begin
            cwr = 1'b1; csel = CSEL_L1; caddr_wr = 12'd5; cdata_wr = DW'($urandom);
            crd = 1'b1; caddr_rd = 12'd5;
            cdata_exp = '0;
        end
        for (int c = 0; c < wait_cycles; c++) begin
            check("start_ready", ready, 1);
            check("start_state", 32'(dbg_state), 32'(ST_START));
            @(negedge clk);
            if (noise) check("start_cdata", cdata_rd, 0);
        end
        check("start_ready_last", ready, 1);
        busy = 1'b1;
        @(negedge clk);
        cwr = 1'b0;
        crd = 1'b0;
        check("start_ready_fall", ready, 0);
        check("start_to_run", 32'(dbg_state), 32'(ST_RUN));
        check("start_ld_ready", ld_ready, 0);
    endtask

    task automatic run_cycle(input bit w, input logic [2:0] sel, input logic [AW-1:0] wa,
                             input logic [DW-1:0] wd, input bit r, input logic [AW-1:0] ra,
                             input logic [AW-1:0] ia, input string tag);
        cwr = w; csel = sel; caddr_wr = wa; cdata_wr = wd;
        crd = r; caddr_rd = ra; iaddr = ia;
        if (r) begin
            if (sel == CSEL_L0)      cdata_exp = l0_m[ra];
            else if (sel == CSEL_L1) cdata_exp = l1_m[ra[L1_AW-1:0]];
            else                     cdata_exp = '0;
        end
        if (w && sel == CSEL_L0) l0_m[wa] = wd;
        if (w && sel == CSEL_L1) l1_m[wa[L1_AW-1:0]] = wd;
        @(negedge clk);
        cwr = 1'b0;
        crd = 1'b0;
        check({tag, "_idata"}, idata, img_m[ia]);
        check({tag, "_cdata"}, cdata_rd, cdata_exp);
    endtask

    task automatic drive_noise();
        cwr = 1'b1;
        csel = $urandom_range(0, 1) ? CSEL_L1 : CSEL_L0;
        caddr_wr = AW'($urandom);
        cdata_wr = DW'($urandom);
        crd = 1'b1;
        caddr_rd = AW'($urandom);
    endtask

    task automatic drain(input int n_words, input bit noise);
        int idx, cyc, since_hs;
        bit pv, pr, plast;
        logic [DW-1:0] pdata, exp_w;
        idx = 0; cyc = 0; since_hs = 0;
        pv = 1'b0; pr = 1'b0; plast = 1'b0; pdata = '0;
        exp_q.delete();
        for (int k = 0; k < L1_DEPTH; k++) exp_q.push_back(l1_m[k]);
        busy = 1'b0; cwr = 1'b0; crd = 1'b0;
        @(negedge clk);
        check("drain_state", 32'(dbg_state), 32'(ST_DRAIN));
        check("drain_valid_1", rd_valid, 0);
        rd_ready = 1'($urandom_range(0, 1));
        if (noise) drive_noise();
        @(negedge clk);
        check("drain_valid_2", rd_valid, 0);
        if (noise) drive_noise();
        @(negedge clk);
        check("drain_valid_3", rd_valid, 1);
        while (idx < n_words && cyc < 20000) begin
            cyc++;
            if (noise) check("drain_cdata_zero", cdata_rd, 0);
            if (since_hs == 1) begin
                check("drain_gap", rd_valid, 0);
            end else if (since_hs == 2) begin
                check("drain_next_valid", rd_valid, 1);
            end else if (pv && !pr) begin
                check("stall_valid", rd_valid, 1);
                check("stall_data", rd_data, pdata);
                check("stall_last", rd_last, plast);
            end
            if (since_hs > 0) since_hs = (since_hs == 2) ? 0 : since_hs + 1;
            rd_ready = ($urandom_range(0, 2) != 0);
            if (rd_valid && rd_ready) begin
                exp_w = exp_q.pop_front();
                check("drain_data", rd_data, exp_w);
                check("drain_last", rd_last, (idx == L1_DEPTH - 1));
                idx++;
                since_hs = 1;
            end
            pv = rd_valid; pr = rd_ready; pdata = rd_data; plast = rd_last;
            if (noise) drive_noise();
            @(negedge clk);
        end
        check("drain_count", idx, n_words);
        rd_ready = 1'b0; cwr = 1'b0; crd = 1'b0;
    endtask

    task automatic check_done();
        check("done_pulse", done, 1);
        check("done_state", 32'(dbg_state), 32'(ST_DONE));
        check("done_rd_valid", rd_valid, 0);
        @(negedge clk);
        check("done_clear", done, 0);
        check("done_to_load", 32'(dbg_state), 32'(ST_LOAD));
        check("done_ld_ready", ld_ready, 1);
    endtask

    initial begin
        reset = 1'b1; ld_valid = 1'b0; ld_data = '0; busy = 1'b0; iaddr = '0;
        crd = 1'b0; caddr_rd = '0; cwr = 1'b0; caddr_wr = '0; cdata_wr = '0;
        csel = 3'b000; rd_ready = 1'b0; cdata_exp = '0;
        repeat (3) @(negedge clk);
        check("rst_ld_ready", ld_ready, 1);
        check("rst_ready", ready, 0);
        check("rst_idata", idata, 0);
        check("rst_cdata", cdata_rd, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_last", rd_last, 0);
        check("rst_done", done, 0);
        check("rst_state", 32'(dbg_state), 32'(ST_LOAD));
        reset = 1'b0;

        // Pass 1: identity image, directed accesses, random traffic, full readout.
        load_image(1'b0);
        start_seq(10, 1'b0);
        run_cycle(0, 3'b000, 0, 0, 0, 0, 12'h0A5, "iaddr_a5");
        check("iaddr_a5_value", idata, 20'h000A5);
        run_cycle(1, CSEL_L0, 12'd7, 20'h12345, 0, 0, 12'h001, "l0_wr7");
        run_cycle(0, CSEL_L0, 0, 0, 1, 12'd7, 12'h002, "l0_rd7");
        check("l0_rd7_value", cdata_rd, 20'h12345);
        run_cycle(1, CSEL_L1, 12'd3, 20'h00010, 0, 0, 12'h003, "l1_wr3");
        run_cycle(1, CSEL_L1, 12'd3, 20'hFFFFF, 1, 12'd3, 12'h004, "rbw_l1_3");
        check("rbw_old_value", cdata_rd, 20'h00010);
        run_cycle(0, CSEL_L1, 0, 0, 1, 12'd3, 12'h005, "l1_rd3_new");
        run_cycle(1, 3'b010, 12'd7, 20'h55555, 0, 0, 12'h006, "bad_wr7");
        run_cycle(1, 3'b010, 12'd3, 20'h55555, 0, 0, 12'h007, "bad_wr3");
        run_cycle(0, CSEL_L0, 0, 0, 1, 12'd7, 12'h008, "l0_rd7_after");
        run_cycle(0, CSEL_L1, 0, 0, 1, 12'd3, 12'h009, "l1_rd3_after");
        run_cycle(0, 3'b010, 0, 0, 1, 12'd7, 12'h00A, "bad_rd");
        run_cycle(0, CSEL_L1, 0, 0, 1, 12'd3, 12'h00B, "l1_rd3_again");
        run_cycle(0, CSEL_L1, 0, 0, 0, 12'd0, 12'h00C, "cdata_hold");
        for (int k = 0; k < 16; k++) begin
            run_cycle(1, CSEL_L0, AW'(k), DW'($urandom), 0, 0, AW'($urandom), "init_l0");
            run_cycle(1, CSEL_L1, AW'(k), DW'($urandom), 0, 0, AW'($urandom), "init_l1");
        end
        for (int n = 0; n < 300; n++) begin
            logic [2:0] ws, rs;
            ws = sels[$urandom_range(0, 4)];
            rs = $urandom_range(0, 1) ? ws : sels[$urandom_range(0, 4)];
            run_cycle(1'($urandom_range(0, 1)), ws, pick_addr(ws), DW'($urandom),
                      1'($urandom_range(0, 1)), pick_addr(rs), AW'($urandom), "rand");
        end
        for (int k = 0; k < L1_DEPTH; k++) begin
            run_cycle(1, CSEL_L1, {2'($urandom_range(0, 3)), 10'(k)}, DW'(k + 1), 0, 0,
                      AW'($urandom), "l1_fill");
        end
        drain(L1_DEPTH, 1'b0);
        check_done();

        // Pass 2: random image, dropped START write, noisy readout, reset mid-drain.
        load_image(1'b1);
        start_seq(4, 1'b1);
        for (int n = 0; n < 40; n++) run_cycle(0, 3'b000, 0, 0, 0, 0, AW'($urandom), "run2");
        drain(100, 1'b1);
        @(negedge clk);
        check("pre_reset_valid", rd_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_rd_valid", rd_valid, 0);
        check("mid_rst_ld_ready", ld_ready, 1);
        check("mid_rst_state", 32'(dbg_state), 32'(ST_LOAD));
        check("mid_rst_ready", ready, 0);
        check("mid_rst_rd_last", rd_last, 0);
        check("mid_rst_cdata", cdata_rd, 0);
        reset = 1'b0;
        cdata_exp = '0;

        // Pass 3: reload and rerun; L1 must still hold k+1.
        load_image(1'b1);
        start_seq(3, 1'b0);
        for (int n = 0; n < 20; n++) run_cycle(0, 3'b000, 0, 0, 0, 0, AW'($urandom), "run3");
        drain(L1_DEPTH, 1'b0);
        check_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
